// File: rtl/spi_sd_master.sv
// SPI mode-0 byte master for the SD-card path. It is driven by single-cycle CPU port strobes
// and holds a one-deep pending request plus a deferred chip-select write while a transfer runs.
module spi_sd_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cs_wr,
  input  logic       data_wr,
  input  logic       data_rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       sd_cs,
  output logic       sd_sck,
  output logic       sd_sdi,
  input  logic       sd_sdo
);

  // state | meaning
  // IDLE  | no transfer, SCK low, MOSI high
  // LOW   | SCK low half-period, current bit on MOSI
  // HIGH  | SCK high half-period, MISO sampled on entry
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] dout_q, dout_d;
  logic       cs_q, cs_d;
  logic       sck_q, sck_d;
  logic       sdi_q, sdi_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic       defer_v_q, defer_v_d;
  logic       defer_q, defer_d;

  logic       strobe;
  logic [7:0] strobe_byte;
  logic       phase_end;
  logic       done;
  logic       start;
  logic [7:0] start_byte;

  assign strobe      = data_wr | data_rd;
  assign strobe_byte = data_wr ? din : 8'hFF;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      bit_q       <= 3'd0;
      tx_q        <= 8'hFF;
      rx_q        <= 8'hFF;
      dout_q      <= 8'hFF;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b1;
      pend_q      <= 1'b0;
      pend_byte_q <= 8'hFF;
      defer_v_q   <= 1'b0;
      defer_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dout_q      <= dout_d;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      defer_v_q   <= defer_v_d;
      defer_q     <= defer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dout_d      = dout_q;
    cs_d        = cs_q;
    sck_d       = sck_q;
    sdi_d       = sdi_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    defer_v_d   = defer_v_q;
    defer_d     = defer_q;
    start       = 1'b0;
    start_byte  = strobe_byte;
    phase_end   = (div_q == DIV_LAST);
    done        = (state_q == HIGH) && phase_end && (bit_q == 3'd7);

    case (state_q)
      IDLE: begin
        if (cs_wr) cs_d = din[0];
        start = strobe;
      end
      LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], sd_sdo};
          div_d   = 8'd0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d = 1'b0;
          div_d = 8'd0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            sdi_d   = tx_q[6];
            state_d = LOW;
          end else begin
            dout_d  = rx_q;
            sdi_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion cycle: deferred CS lands first, then any queued byte starts without an idle gap.
    if (done) begin
      cs_d      = cs_wr ? din[0] : (defer_v_q ? defer_q : cs_q);
      defer_v_d = 1'b0;
      if (pend_q) begin
        start      = 1'b1;
        start_byte = pend_byte_q;
        pend_d     = 1'b0;
      end else begin
        start = strobe;
      end
    end else if (state_q != IDLE) begin
      if (cs_wr) begin
        defer_v_d = 1'b1;
        defer_d   = din[0];
      end
      if (strobe && !pend_q) begin
        pend_d      = 1'b1;
        pend_byte_d = strobe_byte;
      end
    end

    if (start) begin
      state_d = LOW;
      tx_d    = start_byte;
      sdi_d   = start_byte[7];
      sck_d   = 1'b0;
      div_d   = 8'd0;
      bit_d   = 3'd0;
    end
  end

  always_comb begin
    dout   = dout_q;
    busy   = (state_q != IDLE) || pend_q;
    sd_cs  = cs_q;
    sd_sck = sck_q;
    sd_sdi = sdi_q;
  end

endmodule

// File: doc/spi_sd_master.md
Name: spi_sd_master

Overview:
- Z80-side SPI master for the SD-card path (DivMMC/ZXMMC style).
- Turns CPU port strobes into SPI mode-0 byte transfers on sd_cs/sd_sck/sd_sdi/sd_sdo.
- Sits directly upstream of the emulated SD card, which drives its outputs on falling SCK and samples on rising SCK.
- Port address decoding is done outside this block; it receives single-cycle strobes only.

Parameters:
- CLK_DIV, 2, clk_sys cycles per SCK half-period; legal range 1..255.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs_wr  in  1  one-cycle strobe: write chip-select register from din[0].
- data_wr  in  1  one-cycle strobe: start a transfer that sends din.
- data_rd  in  1  one-cycle strobe: start a transfer that sends 8'hFF (read-ahead).
- din  in  8  CPU write data.
- dout  out  8  last completed received byte.
- busy  out  1  high while a transfer is active or pending.
- sd_cs  out  1  card chip select, active low.
- sd_sck  out  1  SPI clock, idles low.
- sd_sdi  out  1  MOSI (card input).
- sd_sdo  in  1  MISO (card output).

Behaviour:
- Reset values (asynchronous while reset_n=0): sd_cs=1, sd_sck=0, sd_sdi=1, dout=8'hFF, busy=0. Internal state: state=IDLE, pending cleared, deferred-CS cleared, divider=0, bit counter=0.
- State machine: IDLE, LOW, HIGH.
- Start from IDLE (data_wr or data_rd sampled in cycle T):
  - At T+1: state=LOW, tx shift register = din (or 8'hFF for data_rd), sd_sdi = bit7, sd_sck=0, busy=1.
- LOW: hold for CLK_DIV cycles. Then sd_sck=1, sample sd_sdo into rx bit0 (rx shifts left), go to HIGH.
- HIGH: hold for CLK_DIV cycles. Then sd_sck=0, and:
  - if bits sent < 8: shift tx left, drive next bit on sd_sdi, go to LOW;
  - after the 8th HIGH: dout = rx, sd_sdi=1, go to IDLE, busy=0 in the same cycle unless a pending transfer exists.
- Transfer length: exactly 16*CLK_DIV cycles from T+1; 8 SCK pulses, MSB first.
- Data direction: sd_sdi changes only on falling SCK or at start; sd_sdo is sampled only on rising SCK.
- data_rd semantics: the CPU reads dout combinationally in the same I/O cycle, so it sees the previous byte; the strobe then launches a 0xFF transfer whose result is available on the next read.
- Strobe while busy with no pending request: latch a one-deep pending request (data byte, or FF for rd).
  - The pending transfer starts on the cycle after completion, with no IDLE gap visible on busy.
  - A further strobe while pending is already set is dropped.
- cs_wr:
  - In IDLE with no pending request: sd_cs = din[0] at the next edge.
  - While busy: value latched as deferred and applied in the completion cycle, before any pending transfer starts. A later cs_wr overwrites the deferred value.
- Simultaneous events:
  - cs_wr together with data_wr in IDLE: CS is updated and the transfer starts, both at T+1.
  - data_wr together with data_rd: data_wr wins.
- Divider: counts 0..CLK_DIV-1 and resets on every phase change.
- reset_n asserted mid-transfer: the transfer is aborted immediately, all outputs take their reset values, and pending/deferred requests are discarded.

Test Plan:
- Reset check: after reset, without toggling clocks, sd_cs=1, sd_sck=0, sd_sdi=1, dout=FF, busy=0.
- Write shape: CLK_DIV=2, data_wr din=8'h40.
  - Exactly 8 SCK pulses, each 2 cycles low / 2 cycles high; sd_sdi sampled at rising SCK reads 0,1,0,0,0,0,0,0.
  - busy high for exactly 32 cycles; sd_sdi=1 afterwards.
- Receive with card model: card model on falling SCK returns 8'hA5; data_wr 8'h00 -> dout=A5 in the completion cycle.
  - Then data_rd: dout still A5 during the transfer and FF after it with an FF card reply; sd_sdi stays 1 for all bits.
- Back-to-back queueing: data_wr 8'h51, then data_wr 8'h00 and data_wr 8'h11 both during busy.
  - Exactly two transfers (51, 00) with no gap; busy continuous for 64 cycles at CLK_DIV=2; 11 is never sent.
- Chip-select deferral: cs_wr din=0 in IDLE -> sd_cs=0 next cycle.
  - cs_wr din=1 mid-transfer -> sd_cs stays 0 until the completion cycle, then 1.
- Reset mid-transfer: reset_n low at the 4th SCK pulse with a pending request.
  - Outputs return to reset values immediately; after release, no transfer starts and busy=0.
